// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: decodes E0/F0 prefixes into make/break events, tracks the held key
// and keeps a BCD press counter. Define PS2_PREFIX_TIMEOUT_EN to abandon stale prefixes.
module ps2_key_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    output logic       key_held,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic [3:0] press_bcd1,
    output logic [3:0] press_bcd0,
    output logic       disp_blank,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic accept;
    logic is_e0, is_f0, drop_code;
    logic emit, emit_brk, emit_ext;
    logic proto_err, tmo_hit;
    logic held_match, new_press, held_release;

    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [3:0] t;
        logic [3:0] o;
        if (ones == 4'd9) begin
            o = 4'd0;
            t = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            o = ones + 4'd1;
            t = tens;
        end
        return {t, o};
    endfunction

    assign in_ready   = !evt_valid || evt_ready;
    assign accept     = in_valid && in_ready;
    assign disp_blank = !key_held;

    assign is_e0     = (in_data == 8'hE0);
    assign is_f0     = (in_data == 8'hF0);
    // Keyboard housekeeping replies (BAT, echo, ack, errors) never form a key event.
    assign drop_code = in_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFF};

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_brk  = 1'b0;
        emit_ext  = 1'b0;
        proto_err = 1'b0;
        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (is_e0) begin
                        state_nxt = EXT;
                    end else if (is_f0) begin
                        state_nxt = BRK;
                    end else if (!drop_code) begin
                        emit = 1'b1;
                    end
                end
                EXT: begin
                    if (is_f0) begin
                        state_nxt = EXT_BRK;
                    end else if (!is_e0) begin
                        emit      = 1'b1;
                        emit_ext  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    state_nxt = IDLE;
                    if (is_e0 || is_f0) begin
                        proto_err = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        emit_ext = (state == EXT_BRK);
                    end
                end
            endcase
        end else if (tmo_hit) begin
            state_nxt = IDLE;
        end
    end

`ifdef PS2_PREFIX_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt;

    // Counts idle cycles spent waiting for the byte that completes a prefix.
    assign tmo_hit = (state != IDLE) && !accept && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if (accept || tmo_hit || state == IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= proto_err || tmo_hit;
        end
    end

    // A new load wins over a simultaneous handshake, so evt_valid stays high with fresh data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            evt_valid <= 1'b0;
            evt_code  <= 8'h00;
            evt_break <= 1'b0;
            evt_ext   <= 1'b0;
        end else if (emit) begin
            evt_valid <= 1'b1;
            evt_code  <= in_data;
            evt_break <= emit_brk;
            evt_ext   <= emit_ext;
        end else if (evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

    assign held_match   = key_held && (key_code == in_data) && (key_ext == emit_ext);
    assign new_press    = emit && !emit_brk && !held_match;
    assign held_release = emit && emit_brk && held_match;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_held   <= 1'b0;
            key_code   <= 8'h00;
            key_ext    <= 1'b0;
            press_bcd1 <= 4'd0;
            press_bcd0 <= 4'd0;
        end else if (new_press) begin
            key_held                 <= 1'b1;
            key_code                 <= in_data;
            key_ext                  <= emit_ext;
            {press_bcd1, press_bcd0} <= bcd_inc(press_bcd1, press_bcd0);
        end else if (held_release) begin
            key_held <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: vector table, hand-written corner sequences and a randomized run
// scored against a rule-level model (prefix flags, event queue, integer press count).
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic       key_held;
    logic [7:0] key_code;
    logic       key_ext;
    logic [3:0] press_bcd1;
    logic [3:0] press_bcd0;
    logic       disp_blank;
    logic       err;

    always #5 clk = ~clk;

    ps2_key_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_break (evt_break),
        .evt_ext   (evt_ext),
        .key_held  (key_held),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .press_bcd1(press_bcd1),
        .press_bcd0(press_bcd0),
        .disp_blank(disp_blank),
        .err       (err)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } evt_t;

    evt_t       exp_q[$];
    logic       pend_ext, pend_brk;
    logic       m_held, m_ext, m_err;
    logic [7:0] m_code;
    int         m_count;

    task automatic model_clear();
        pend_ext = 1'b0; pend_brk = 1'b0;
        m_held = 1'b0; m_ext = 1'b0; m_code = 8'h00; m_count = 0; m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_event(input logic [7:0] code, input logic brk, input logic ext);
        evt_t e;
        e.code = code; e.brk = brk; e.ext = ext;
        exp_q.push_back(e);
        if (!brk) begin
            if (!m_held || code != m_code || ext != m_ext) begin
                m_held = 1'b1; m_code = code; m_ext = ext;
                m_count = (m_count + 1) % 100;
            end
        end else if (m_held && code == m_code && ext == m_ext) begin
            m_held = 1'b0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_err = 1'b0;
        if (pend_brk) begin
            if (b == 8'hE0 || b == 8'hF0) m_err = 1'b1;
            else model_event(b, 1'b1, pend_ext);
            pend_brk = 1'b0; pend_ext = 1'b0;
        end else if (pend_ext) begin
            if (b == 8'hF0) pend_brk = 1'b1;
            else if (b != 8'hE0) begin
                model_event(b, 1'b0, 1'b1);
                pend_ext = 1'b0;
            end
        end else begin
            if (b == 8'hE0) pend_ext = 1'b1;
            else if (b == 8'hF0) pend_brk = 1'b1;
            else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFF})) model_event(b, 1'b0, 1'b0);
        end
    endtask

    function automatic logic [31:0] bcd_of(input int c);
        return 32'((c / 10) * 16 + (c % 10));
    endfunction

    // ---------------- cycle helpers ----------------
    logic mon_en = 1'b0;
    logic rnd_ready = 1'b0;
    int   zeros = 0;

    task automatic mon();
        evt_t x;
        if (mon_en && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("evt_unexpected_valid", 32'(evt_valid), 32'd0);
            end else begin
                x = exp_q.pop_front();
                check("rnd_evt_code", 32'(evt_code), 32'(x.code));
                check("rnd_evt_break", 32'(evt_break), 32'(x.brk));
                check("rnd_evt_ext", 32'(evt_ext), 32'(x.ext));
            end
        end
    endtask

    task automatic rand_ready();
        if (rnd_ready) begin
            if (zeros >= 3) evt_ready = 1'b1;
            else evt_ready = ($urandom_range(0, 3) != 0);
            zeros = evt_ready ? 0 : zeros + 1;
        end
    endtask

    task automatic to_negedge();
        @(negedge clk);
        mon();
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
        rand_ready();
    endtask

    task automatic put_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data = b;
        for (int i = 0; i < 64 && !ok; i++) begin
            to_negedge();
            ok = in_ready;
            to_drive();
        end
        in_valid = 1'b0;
        check("byte_accepted", 32'(ok), 32'd1);
        if (ok) model_byte(b);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; evt_ready = 1'b0; rnd_ready = 1'b0; mon_en = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        model_clear();
    endtask

    task automatic check_track(input string tag);
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_held"}, 32'(key_held), 32'(m_held));
        check({tag, "_blank"}, 32'(disp_blank), 32'(!m_held));
        check({tag, "_kcode"}, 32'(key_code), 32'(m_code));
        check({tag, "_kext"}, 32'(key_ext), 32'(m_ext));
        check({tag, "_cnt"}, 32'({press_bcd1, press_bcd0}), bcd_of(m_count));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2;
        logic       ev;
        logic [7:0] code;
        logic       brk, ext, er, held;
        logic [7:0] kcode;
        logic       kext;
        logic [7:0] cnt;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic ev, input logic [7:0] code,
                                input logic brk, input logic ext, input logic er, input logic held,
                                input logic [7:0] kcode, input logic kext, input logic [7:0] cnt);
        vec_t v;
        v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.ev = ev; v.code = code; v.brk = brk;
        v.ext = ext; v.er = er; v.held = held; v.kcode = kcode; v.kext = kext; v.cnt = cnt;
        return v;
    endfunction

    localparam int NV = 17;
    vec_t tbl[NV];
    logic [7:0] pool[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b, x;
        int hit;

        //          n  b0     b1     b2     ev    code   brk   ext   err   held  kcode  kext  cnt
        tbl[0]  = mk(1, 8'h1C, 8'h00, 8'h00, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'h01);
        tbl[1]  = mk(2, 8'hF0, 8'h1C, 8'h00, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 8'h01);
        tbl[2]  = mk(1, 8'h1C, 8'h00, 8'h00, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'h02);
        tbl[3]  = mk(1, 8'h1C, 8'h00, 8'h00, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'h02);
        tbl[4]  = mk(2, 8'hF0, 8'h1C, 8'h00, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 8'h02);
        tbl[5]  = mk(2, 8'hE0, 8'h75, 8'h00, 1'b1, 8'h75, 1'b0, 1'b1, 1'b0, 1'b1, 8'h75, 1'b1, 8'h03);
        tbl[6]  = mk(3, 8'hE0, 8'hF0, 8'h75, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0, 8'h75, 1'b1, 8'h03);
        tbl[7]  = mk(1, 8'hAA, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 8'h03);
        tbl[8]  = mk(2, 8'hF0, 8'hF0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h75, 1'b1, 8'h03);
        tbl[9]  = mk(3, 8'hE0, 8'hE0, 8'h6B, 1'b1, 8'h6B, 1'b0, 1'b1, 1'b0, 1'b1, 8'h6B, 1'b1, 8'h04);
        tbl[10] = mk(2, 8'hF0, 8'h32, 8'h00, 1'b1, 8'h32, 1'b1, 1'b0, 1'b0, 1'b1, 8'h6B, 1'b1, 8'h04);
        tbl[11] = mk(1, 8'h75, 8'h00, 8'h00, 1'b1, 8'h75, 1'b0, 1'b0, 1'b0, 1'b1, 8'h75, 1'b0, 8'h05);
        tbl[12] = mk(3, 8'hE0, 8'hF0, 8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h75, 1'b0, 8'h05);
        tbl[13] = mk(1, 8'hFA, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h75, 1'b0, 8'h05);
        tbl[14] = mk(2, 8'hE0, 8'h75, 8'h00, 1'b1, 8'h75, 1'b0, 1'b1, 1'b0, 1'b1, 8'h75, 1'b1, 8'h06);
        tbl[15] = mk(2, 8'hF0, 8'h75, 8'h00, 1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 1'b1, 8'h75, 1'b1, 8'h06);
        tbl[16] = mk(3, 8'hE0, 8'hF0, 8'h75, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0, 8'h75, 1'b1, 8'h06);

        pool = '{8'h1C, 8'h32, 8'h75, 8'h6B, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hAA, 8'h00, 8'hFA, 8'h1C};

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_code", 32'(evt_code), 32'd0);
        check("rst_key_held", 32'(key_held), 32'd0);
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_disp_blank", 32'(disp_blank), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", 32'({press_bcd1, press_bcd0}), 32'd0);
        @(posedge clk);
        #1;

        // ---- table-driven vectors, consumer always ready ----
        evt_ready = 1'b1;
        for (int r = 0; r < NV; r++) begin
            for (int j = 0; j < tbl[r].n; j++) begin
                x = (j == 0) ? tbl[r].b0 : (j == 1) ? tbl[r].b1 : tbl[r].b2;
                put_byte(x);
            end
            to_negedge();
            check($sformatf("vec%0d_evt_valid", r), 32'(evt_valid), 32'(tbl[r].ev));
            if (tbl[r].ev) begin
                check($sformatf("vec%0d_evt_code", r), 32'(evt_code), 32'(tbl[r].code));
                check($sformatf("vec%0d_evt_break", r), 32'(evt_break), 32'(tbl[r].brk));
                check($sformatf("vec%0d_evt_ext", r), 32'(evt_ext), 32'(tbl[r].ext));
            end
            check($sformatf("vec%0d_err", r), 32'(err), 32'(tbl[r].er));
            check($sformatf("vec%0d_held", r), 32'(key_held), 32'(tbl[r].held));
            check($sformatf("vec%0d_blank", r), 32'(disp_blank), 32'(!tbl[r].held));
            check($sformatf("vec%0d_kcode", r), 32'(key_code), 32'(tbl[r].kcode));
            check($sformatf("vec%0d_kext", r), 32'(key_ext), 32'(tbl[r].kext));
            check($sformatf("vec%0d_cnt", r), 32'({press_bcd1, press_bcd0}), 32'(tbl[r].cnt));
            to_drive();
        end

        // ---- backpressure: 32 held off until 1C is taken ----
        do_reset();
        put_byte(8'h1C);
        in_valid = 1'b1;
        in_data = 8'h32;
        for (int i = 0; i < 3; i++) begin
            to_negedge();
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_evt_valid", 32'(evt_valid), 32'd1);
            check("bp_evt_code_stable", 32'(evt_code), 32'h1C);
            to_drive();
        end
        evt_ready = 1'b1;
        to_negedge();
        check("bp_in_ready_high", 32'(in_ready), 32'd1);
        to_drive();
        in_valid = 1'b0;
        to_negedge();
        check("bp_reload_valid", 32'(evt_valid), 32'd1);
        check("bp_reload_code", 32'(evt_code), 32'h32);
        check("bp_key_code", 32'(key_code), 32'h32);
        check("bp_cnt", 32'({press_bcd1, press_bcd0}), 32'h02);
        to_drive();
        to_negedge();
        check("bp_drained", 32'(evt_valid), 32'd0);
        to_drive();

        // ---- counter wrap over 100 distinct presses ----
        do_reset();
        evt_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            put_byte(8'h1C);
            if (i == 99 || i == 100) begin
                to_negedge();
                check($sformatf("wrap_cnt_after_%0d", i), 32'({press_bcd1, press_bcd0}), bcd_of(m_count));
                check($sformatf("wrap_err_after_%0d", i), 32'(err), 32'd0);
                to_drive();
            end
            put_byte(8'hF0);
            put_byte(8'h1C);
        end
        check("wrap_model_cnt", 32'({press_bcd1, press_bcd0}), 32'h00);

        // ---- reset in the middle of a break sequence, then with an event pending ----
        put_byte(8'h1C);
        put_byte(8'hF0);
        resetn = 1'b0;
        #2;
        check("midrst_cnt", 32'({press_bcd1, press_bcd0}), 32'd0);
        check("midrst_held", 32'(key_held), 32'd0);
        #1;
        resetn = 1'b1;
        model_clear();
        to_drive();
        put_byte(8'h1C);
        to_negedge();
        check("midrst_make_valid", 32'(evt_valid), 32'd1);
        check("midrst_make_brk", 32'(evt_break), 32'd0);
        check("midrst_make_cnt", 32'({press_bcd1, press_bcd0}), 32'h01);
        to_drive();
        evt_ready = 1'b0;
        put_byte(8'h32);
        resetn = 1'b0;
        #2;
        check("midrst_pending_cleared", 32'(evt_valid), 32'd0);
        #1;
        resetn = 1'b1;
        model_clear();
        to_drive();

`ifdef PS2_PREFIX_TIMEOUT_EN
        // ---- stale E0 is abandoned after 16 idle cycles ----
        evt_ready = 1'b1;
        put_byte(8'hE0);
        hit = -1;
        for (int i = 0; i < 40 && hit < 0; i++) begin
            to_negedge();
            if (err) hit = i;
            else to_drive();
        end
        check("tmo_err_cycle", 32'(hit), 32'd16);
        check("tmo_no_event", 32'(evt_valid), 32'd0);
        to_drive();
        model_clear();
        put_byte(8'h1C);
        to_negedge();
        check("tmo_after_valid", 32'(evt_valid), 32'd1);
        check("tmo_after_ext", 32'(evt_ext), 32'd0);
        check("tmo_after_err", 32'(err), 32'd0);
        to_drive();
`else
        // ---- without the timeout a prefix waits indefinitely ----
        evt_ready = 1'b1;
        put_byte(8'hE0);
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            to_negedge();
            if (err) hit++;
            to_drive();
        end
        check("noto_err_count", 32'(hit), 32'd0);
        put_byte(8'h75);
        to_negedge();
        check("noto_valid", 32'(evt_valid), 32'd1);
        check("noto_ext", 32'(evt_ext), 32'd1);
        to_drive();
`endif

        // ---- randomized run against the model, random consumer backpressure ----
        do_reset();
        mon_en = 1'b1;
        rnd_ready = 1'b1;
        zeros = 0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 11) == 11) b = 8'($urandom_range(0, 255));
            else b = pool[$urandom_range(0, 11)];
            put_byte(b);
            to_negedge();
            check_track("rnd");
            to_drive();
        end
        rnd_ready = 1'b0;
        evt_ready = 1'b1;
        repeat (4) begin
            to_negedge();
            to_drive();
        end
        check("rnd_queue_drained", 32'(exp_q.size()), 32'd0);
        check("rnd_evt_valid_idle", 32'(evt_valid), 32'd0);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
